// File: rtl/seq_pkg.sv
// Shared types and default sizing for the serializer slice (seq_serializer and seq_fifo).
package seq_pkg;

   localparam int DEFAULT_DATA_W     = 8;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/seq_fifo.sv
// Word FIFO feeding the serializer: extra pointer MSB distinguishes full from empty.
module seq_fifo
   import seq_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic              do_push;
   logic              do_pop;

   // Push is refused while full even if a pop happens in the same cycle.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, do_pop};
      pop_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/seq_serializer.sv
// Buffered MSB-first parallel-to-serial converter with downstream pause.
// Define SEQ_SER_GAP_EN to insert one idle cycle after every word.
module seq_serializer
   import seq_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              pause,
   output logic              seq_out,
   output logic              valid_out,
   output logic              busy
);

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              in_shift;

   seq_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (data_valid),
      .push_data (data_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // The final shift of a word empties sreg, so IDLE is always entered with sreg cleared.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      fifo_pop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               sreg_d    = fifo_data;
               bit_cnt_d = LAST_CNT;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (!pause) begin
               sreg_d    = {sreg_q[DATA_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - CNT_W'(1);
               if (bit_cnt_q == '0) begin
                  bit_cnt_d = '0;
`ifdef SEQ_SER_GAP_EN
                  state_d = GAP;
`else
                  if (!fifo_empty) begin
                     fifo_pop  = 1'b1;
                     sreg_d    = fifo_data;
                     bit_cnt_d = LAST_CNT;
                  end else begin
                     state_d = IDLE;
                  end
`endif
               end
            end
         end
`ifdef SEQ_SER_GAP_EN
         GAP: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               sreg_d    = fifo_data;
               bit_cnt_d = LAST_CNT;
               state_d   = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   always_comb begin
      in_shift   = (state_q == SHIFT);
      valid_out  = in_shift && !pause;
      seq_out    = in_shift && sreg_q[DATA_W-1];
      busy       = (state_q != IDLE) || !fifo_empty;
      data_ready = !fifo_full;
   end

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized self-checking bench for seq_serializer: the emitted bit stream is
// compared against the MSB-first concatenation of every word the bench saw accepted.
module tb_seq_serializer;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;
`ifdef SEQ_SER_GAP_EN
   localparam int EXP_GAP = 2;
`else
   localparam int EXP_GAP = 1;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [DATA_W-1:0] data_in = '0;
   logic              data_valid = 1'b0;
   logic              pause = 1'b0;
   logic              data_ready;
   logic              seq_out;
   logic              valid_out;
   logic              busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit obs_q[$];
   int obs_cyc[$];
   bit exp_q[$];

   seq_serializer #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .pause      (pause),
      .seq_out    (seq_out),
      .valid_out  (valid_out),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (valid_out === 1'b1) begin
         obs_q.push_back(seq_out);
         obs_cyc.push_back(cyc);
      end
   end

   task automatic add_exp(input logic [DATA_W-1:0] w);
      for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(w[i]);
   endtask

   task automatic clear_streams;
      obs_q.delete();
      obs_cyc.delete();
      exp_q.delete();
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle(input int limit, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (busy === 1'b0 && valid_out === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
      checks++; if (seq_out !== 1'b0) begin failures++; $display("FAIL reset_seq_out: got %b expected 0", seq_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL reset_data_ready: got %b expected 1", data_ready); end
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_single_word;
      bit to;
      int push_edge;
      clear_streams();
      add_exp(8'hB2);
      data_in = 8'hB2;
      data_valid = 1'b1;
      step();
      push_edge = cyc;
      data_valid = 1'b0;
      wait_idle(40, to);
      checks++; if (to) begin failures++; $display("FAIL single_idle_timeout: got busy %b expected 0", busy); end
      checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL single_count: got %0d expected 8", obs_q.size()); end
      if (obs_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_bit%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
         end
         checks++; if (obs_cyc[0] != push_edge + 1) begin failures++; $display("FAIL single_latency: got cycle %0d expected %0d", obs_cyc[0], push_edge + 1); end
         checks++; if (obs_cyc[7] - obs_cyc[0] != 7) begin failures++; $display("FAIL single_contiguous: got span %0d expected 7", obs_cyc[7] - obs_cyc[0]); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back;
      bit to;
      clear_streams();
      add_exp(8'hFF);
      add_exp(8'h00);
      data_in = 8'hFF;
      data_valid = 1'b1;
      step();
      data_in = 8'h00;
      step();
      data_valid = 1'b0;
      wait_idle(60, to);
      checks++; if (to) begin failures++; $display("FAIL b2b_idle_timeout: got busy %b expected 0", busy); end
      checks++; if (obs_q.size() != 16) begin failures++; $display("FAIL b2b_count: got %0d expected 16", obs_q.size()); end
      if (obs_q.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_bit%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
         end
         checks++; if (obs_cyc[8] - obs_cyc[7] != EXP_GAP) begin failures++; $display("FAIL b2b_word_gap: got %0d expected %0d", obs_cyc[8] - obs_cyc[7], EXP_GAP); end
         checks++; if (obs_cyc[15] - obs_cyc[0] != 14 + EXP_GAP) begin failures++; $display("FAIL b2b_span: got %0d expected %0d", obs_cyc[15] - obs_cyc[0], 14 + EXP_GAP); end
      end
   endtask

   task automatic test_fifo_full;
      bit to;
      int buffered;
      logic [DATA_W-1:0] w [6];
      clear_streams();
      for (int i = 0; i < 6; i++) w[i] = DATA_W'($urandom);
      pause = 1'b1;
      for (int n = 0; n < 5; n++) begin
         data_in = w[n];
         data_valid = 1'b1;
         step();
         add_exp(w[n]);
         // the first word leaves the FIFO for the shift register one edge after it lands
         buffered = (n == 0) ? 1 : n;
         checks++; if (data_ready !== (buffered < FIFO_DEPTH)) begin failures++; $display("FAIL full_ready_after_push%0d: got %b expected %b", n, data_ready, buffered < FIFO_DEPTH); end
      end
      data_in = w[5];
      step();
      data_valid = 1'b0;
      checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL full_ready_after_drop: got %b expected 0", data_ready); end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL full_no_output_while_paused: got %0d expected 0", obs_q.size()); end
      pause = 1'b0;
      wait_idle(200, to);
      checks++; if (to) begin failures++; $display("FAIL full_idle_timeout: got busy %b expected 0", busy); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL full_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_bit%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_pause;
      bit to;
      int waited;
      clear_streams();
      add_exp(8'hA5);
      data_in = 8'hA5;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      waited = 0;
      while (obs_q.size() < 3 && waited < 40) begin
         step();
         waited++;
      end
      checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL pause_reach_bit3: got %0d expected 3", obs_q.size()); end
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL pause_valid_low%0d: got %b expected 0", i, valid_out); end
         checks++; if (seq_out !== exp_q[3]) begin failures++; $display("FAIL pause_bit4_held%0d: got %b expected %b", i, seq_out, exp_q[3]); end
      end
      @(posedge clock);
      #1 pause = 1'b0;
      wait_idle(40, to);
      checks++; if (to) begin failures++; $display("FAIL pause_idle_timeout: got busy %b expected 0", busy); end
      checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL pause_count: got %0d expected 8", obs_q.size()); end
      if (obs_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL pause_bit%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
         end
         checks++; if (obs_cyc[3] - obs_cyc[2] != 4) begin failures++; $display("FAIL pause_hole: got %0d expected 4", obs_cyc[3] - obs_cyc[2]); end
      end
   endtask

   task automatic test_reset_midword;
      int waited;
      clear_streams();
      for (int n = 0; n < 3; n++) begin
         data_in = DATA_W'($urandom);
         data_valid = 1'b1;
         step();
      end
      data_valid = 1'b0;
      waited = 0;
      while (obs_q.size() < 5 && waited < 40) begin
         step();
         waited++;
      end
      checks++; if (obs_q.size() != 5) begin failures++; $display("FAIL rstmid_reach_bit5: got %0d expected 5", obs_q.size()); end
      reset = 1'b1;
      #1;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_valid_out: got %b expected 0", valid_out); end
      checks++; if (seq_out !== 1'b0) begin failures++; $display("FAIL rstmid_seq_out: got %b expected 0", seq_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL rstmid_data_ready: got %b expected 1", data_ready); end
      step();
      step();
      reset = 1'b0;
      clear_streams();
      repeat (30) step();
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_residual_bits: got %0d expected 0", obs_q.size()); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_random;
      bit to;
      int idx;
      int budget;
      logic [DATA_W-1:0] words [12];
      for (int round = 0; round < 3; round++) begin
         clear_streams();
         for (int i = 0; i < 12; i++) words[i] = DATA_W'($urandom);
         idx = 0;
         budget = 0;
         while (idx < 12 && budget < 2000) begin
            pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
               data_in = words[idx];
               data_valid = 1'b1;
               if (data_ready === 1'b1) begin
                  add_exp(words[idx]);
                  idx++;
               end
            end else begin
               data_valid = 1'b0;
            end
            step();
            budget++;
         end
         data_valid = 1'b0;
         pause = 1'b0;
         checks++; if (idx != 12) begin failures++; $display("FAIL rand%0d_push_budget: got %0d expected 12", round, idx); end
         wait_idle(400, to);
         checks++; if (to) begin failures++; $display("FAIL rand%0d_idle_timeout: got busy %b expected 0", round, busy); end
         checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count: got %0d expected %0d", round, obs_q.size(), exp_q.size()); end
         for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_bit%0d: got %b expected %b", round, i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_fifo_full();
      test_pause();
      test_reset_midword();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
